// File: rtl/i2s_bulk_axis_packer.sv
// Drains one bulk of BULK_BYTES entries from the I2S receiver FIFO and emits it as an
// AXI4-Stream packet: a sync/id/length header beat followed by big-endian 32-bit payload beats.
module i2s_bulk_axis_packer #(
  parameter int          C_M_AXIS_TDATA_WIDTH = 32,
  parameter int          FIFO_DATA_WIDTH      = 16,
  parameter int          ID_WIDTH             = 5,
  parameter int          BULK_BYTES           = 15,
  parameter logic [15:0] SYNC_WORD            = 16'hA55A
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            r_ready,
  output logic                            r_enable,
  input  logic [FIFO_DATA_WIDTH-1:0]      rdata,
  input  logic                            error_empty,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic [15:0]                     bulk_count,
  output logic                            error_id,
  output logic                            error_underrun
);

  localparam logic [7:0] BB8 = BULK_BYTES[7:0];

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_CAP, HDR, DATA} state_t;

  state_t               state_q, state_d;
  logic [7:0]           byte_cnt_q, byte_cnt_d;
  logic [31:0]          word_q, word_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
  logic [15:0]          bulk_count_q, bulk_count_d;
  logic                 error_id_q, error_id_d;
  logic                 error_underrun_q, error_underrun_d;

  logic [ID_WIDTH-1:0]  rd_id;
  logic [7:0]           rd_byte;
  logic                 last_byte;
  logic                 unused_rdata;

  assign rd_id        = rdata[8 +: ID_WIDTH];
  assign rd_byte      = rdata[7:0];
  assign unused_rdata = ^rdata[FIFO_DATA_WIDTH-1:8+ID_WIDTH];
  // True in RD_CAP when the byte being captured completes the bulk.
  assign last_byte    = ((byte_cnt_q + 8'd1) == BB8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      byte_cnt_q       <= '0;
      word_q           <= '0;
      id_q             <= '0;
      bulk_count_q     <= '0;
      error_id_q       <= 1'b0;
      error_underrun_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      byte_cnt_q       <= byte_cnt_d;
      word_q           <= word_d;
      id_q             <= id_d;
      bulk_count_q     <= bulk_count_d;
      error_id_q       <= error_id_d;
      error_underrun_q <= error_underrun_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    byte_cnt_d       = byte_cnt_q;
    word_d           = word_q;
    id_d             = id_q;
    bulk_count_d     = bulk_count_q;
    error_id_d       = error_id_q;
    error_underrun_d = error_underrun_q | (error_empty && (state_q != IDLE));
    r_enable         = 1'b0;
    m_axis_tvalid    = 1'b0;
    m_axis_tdata     = '0;
    m_axis_tlast     = 1'b0;

    case (state_q)
      IDLE: begin
        if (r_ready) begin
          byte_cnt_d = '0;
          state_d    = RD_REQ;
        end
      end
      RD_REQ: begin
        r_enable = 1'b1;
        state_d  = RD_CAP;
      end
      RD_CAP: begin
        // Lane 0 is the most significant byte of the beat (big-endian packing).
        case (byte_cnt_q[1:0])
          2'd0:    word_d[31:24] = rd_byte;
          2'd1:    word_d[23:16] = rd_byte;
          2'd2:    word_d[15:8]  = rd_byte;
          default: word_d[7:0]   = rd_byte;
        endcase
        byte_cnt_d = byte_cnt_q + 8'd1;
        if (byte_cnt_q == 8'd0) begin
          id_d    = rd_id;
          state_d = HDR;
        end else begin
          if (rd_id != id_q) error_id_d = 1'b1;
          if ((byte_cnt_q[1:0] == 2'd3) || last_byte) state_d = DATA;
          else                                        state_d = RD_REQ;
        end
      end
      HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {SYNC_WORD, {(8-ID_WIDTH){1'b0}}, id_q, BB8};
        if (m_axis_tready) begin
          state_d = (byte_cnt_q == BB8) ? DATA : RD_REQ;
        end
      end
      DATA: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = word_q;
        m_axis_tlast  = (byte_cnt_q == BB8);
        if (m_axis_tready) begin
          word_d = '0;
          if (byte_cnt_q == BB8) begin
            bulk_count_d = bulk_count_q + 16'd1;
            state_d      = IDLE;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bulk_count     = bulk_count_q;
  assign error_id       = error_id_q;
  assign error_underrun = error_underrun_q;

endmodule

// File: tb/tb_i2s_bulk_axis_packer.sv
// Directed bench for i2s_bulk_axis_packer: FIFO models feed two instances (15-byte and 4-byte
// bulks) and a scoreboard of expected beats is popped on every AXIS handshake.
module tb_i2s_bulk_axis_packer;
  localparam int BB_A = 15;
  localparam int BB_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        r_ready_a = 1'b0, r_enable_a, error_empty_a = 1'b0;
  logic        tvalid_a, tready_a = 1'b1, tlast_a, err_id_a, err_un_a;
  logic [15:0] rdata_a = 16'h0, bulk_count_a;
  logic [31:0] tdata_a;
  logic        r_ready_b = 1'b0, r_enable_b, error_empty_b = 1'b0;
  logic        tvalid_b, tready_b = 1'b1, tlast_b, err_id_b, err_un_b;
  logic [15:0] rdata_b = 16'h0, bulk_count_b;
  logic [31:0] tdata_b;

  logic [15:0] fifo_a[$], fifo_b[$];
  logic [32:0] exp_a[$], exp_b[$];
  int n_pass = 0, n_total = 0, n_fail = 0;
  int ren_a = 0, ren_b = 0, beats_a = 0, beats_b = 0;
  logic        pend_a = 1'b0, plast_a = 1'b0;
  logic [31:0] pdata_a = '0;
  logic [32:0] e_a, e_b;

  i2s_bulk_axis_packer #(.BULK_BYTES(BB_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .r_ready(r_ready_a), .r_enable(r_enable_a), .rdata(rdata_a),
    .error_empty(error_empty_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a),
    .m_axis_tdata(tdata_a), .m_axis_tlast(tlast_a), .bulk_count(bulk_count_a),
    .error_id(err_id_a), .error_underrun(err_un_a));

  i2s_bulk_axis_packer #(.BULK_BYTES(BB_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .r_ready(r_ready_b), .r_enable(r_enable_b), .rdata(rdata_b),
    .error_empty(error_empty_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b),
    .m_axis_tdata(tdata_b), .m_axis_tlast(tlast_b), .bulk_count(bulk_count_b),
    .error_id(err_id_b), .error_underrun(err_un_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Queue one bulk into a FIFO model and its expected packet into the scoreboard.
  task automatic load(input int which, input int bb, input logic [4:0] id,
                      input logic [7:0] first, input logic [7:0] step, input int bad);
    logic [31:0] w;
    logic [7:0]  b, bb8;
    logic [4:0]  idb;
    bb8 = bb[7:0];
    w   = '0;
    b   = first;
    if (which == 0) exp_a.push_back({1'b0, 16'hA55A, 3'b000, id, bb8});
    else            exp_b.push_back({1'b0, 16'hA55A, 3'b000, id, bb8});
    for (int i = 0; i < bb; i++) begin
      idb = (i == bad) ? 5'd4 : id;
      if (which == 0) fifo_a.push_back({3'b000, idb, b});
      else            fifo_b.push_back({3'b000, idb, b});
      w[31-8*(i%4) -: 8] = b;
      if ((i % 4 == 3) || (i == bb - 1)) begin
        if (which == 0) exp_a.push_back({(i == bb - 1), w});
        else            exp_b.push_back({(i == bb - 1), w});
        w = '0;
      end
      b = b + step;
    end
  endtask

  task automatic wait_done(input int which, input int budget);
    int k = 0;
    while (k < budget && ((which == 0) ? (exp_a.size() != 0 || tvalid_a)
                                       : (exp_b.size() != 0 || tvalid_b))) begin
      @(posedge clk); #1; k++;
    end
    if (which == 0) chk("a_drain_left", exp_a.size(), 0);
    else            chk("b_drain_left", exp_b.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // FIFO models: data appears the cycle after r_enable; r_ready reflects occupancy.
  initial forever begin
    @(negedge clk);
    if (r_enable_a) begin
      ren_a++;
      if (fifo_a.size() > 0) rdata_a = fifo_a.pop_front();
      else                   rdata_a = 16'h0;
    end
    r_ready_a = (fifo_a.size() >= BB_A);
  end

  initial forever begin
    @(negedge clk);
    if (r_enable_b) begin
      ren_b++;
      if (fifo_b.size() > 0) rdata_b = fifo_b.pop_front();
      else                   rdata_b = 16'h0;
    end
    r_ready_b = (fifo_b.size() >= BB_B);
  end

  // Output monitors: stall stability and scoreboard compare on each handshake.
  initial forever begin
    @(negedge clk);
    if (pend_a) begin
      chk("a_stall_tvalid", tvalid_a, 1);
      chk("a_stall_tdata", tdata_a, pdata_a);
      chk("a_stall_tlast", tlast_a, plast_a);
      chk("a_stall_renable", r_enable_a, 0);
    end
    if (tvalid_a && tready_a) begin
      if (exp_a.size() == 0) chk("a_unexpected_beat", tvalid_a, 0);
      else begin
        e_a = exp_a.pop_front();
        chk("a_tdata", tdata_a, e_a[31:0]);
        chk("a_tlast", tlast_a, e_a[32]);
        beats_a++;
      end
    end
    pend_a  = tvalid_a && !tready_a;
    pdata_a = tdata_a;
    plast_a = tlast_a;
  end

  initial forever begin
    @(negedge clk);
    if (tvalid_b && tready_b) begin
      if (exp_b.size() == 0) chk("b_unexpected_beat", tvalid_b, 0);
      else begin
        e_b = exp_b.pop_front();
        chk("b_tdata", tdata_b, e_b[31:0]);
        chk("b_tlast", tlast_b, e_b[32]);
        beats_b++;
      end
    end
  end

  initial begin
    int k, lat, r0, base;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", tvalid_a, 0);
    chk("rst_tdata", tdata_a, 0);
    chk("rst_tlast", tlast_a, 0);
    chk("rst_renable", r_enable_a, 0);
    chk("rst_bulk_count", bulk_count_a, 0);
    chk("rst_error_id", err_id_a, 0);
    chk("rst_error_underrun", err_un_a, 0);
    chk("rst_b_tvalid", tvalid_b, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single 15-byte bulk, tready always high, plus header latency.
    r0 = ren_a;
    load(0, BB_A, 5'd3, 8'h01, 8'h01, -1);
    k = 0;
    while (!r_ready_a && k < 10) begin @(posedge clk); k++; end
    #1;
    lat = 1;
    while (!tvalid_a && lat < 10) begin @(posedge clk); #1; lat++; end
    chk("s1_hdr_latency", lat, 3);
    wait_done(0, 300);
    chk("s1_bulk_count", bulk_count_a, 1);
    chk("s1_renable_pulses", ren_a - r0, 15);

    // Same bulk with a 10-cycle stall on the third beat.
    r0   = ren_a;
    base = beats_a;
    load(0, BB_A, 5'd3, 8'h01, 8'h01, -1);
    k = 0;
    while (beats_a < base + 2 && k < 200) begin @(posedge clk); #1; k++; end
    chk("s2_two_beats_seen", beats_a - base, 2);
    tready_a = 1'b0;
    k = 0;
    while (!tvalid_a && k < 20) begin @(posedge clk); #1; k++; end
    chk("s2_beat3_data", tdata_a, 32'h05060708);
    repeat (10) @(posedge clk);
    #1;
    tready_a = 1'b1;
    wait_done(0, 300);
    chk("s2_bulk_count", bulk_count_a, 2);
    chk("s2_renable_pulses", ren_a - r0, 15);

    // Two bulks queued together: back-to-back packets.
    r0 = ren_a;
    load(0, BB_A, 5'd3, 8'h01, 8'h01, -1);
    load(0, BB_A, 5'd3, 8'h11, 8'h01, -1);
    wait_done(0, 600);
    chk("s3_bulk_count", bulk_count_a, 4);
    chk("s3_renable_pulses", ren_a - r0, 30);

    // Byte 7 carries a foreign id; then an underrun flagged during the next packet.
    chk("s4_error_id_before", err_id_a, 0);
    load(0, BB_A, 5'd3, 8'h01, 8'h01, 7);
    wait_done(0, 300);
    chk("s4_error_id_set", err_id_a, 1);
    chk("s4_underrun_clear", err_un_a, 0);
    load(0, BB_A, 5'd3, 8'h21, 8'h01, -1);
    k = 0;
    while (!r_enable_a && k < 20) begin @(posedge clk); #1; k++; end
    error_empty_a = 1'b1;
    @(posedge clk); #1;
    error_empty_a = 1'b0;
    wait_done(0, 300);
    chk("s4_error_id_sticky", err_id_a, 1);
    chk("s4_underrun_set", err_un_a, 1);
    chk("s4_bulk_count", bulk_count_a, 6);

    // Asynchronous reset after the second beat handshake, then a fresh packet.
    base = beats_a;
    load(0, BB_A, 5'd3, 8'h01, 8'h01, -1);
    k = 0;
    while (beats_a < base + 2 && k < 200) begin @(posedge clk); #1; k++; end
    #1;
    rst_n = 1'b0;
    #1;
    chk("s5_tvalid", tvalid_a, 0);
    chk("s5_renable", r_enable_a, 0);
    chk("s5_tdata", tdata_a, 0);
    chk("s5_bulk_count", bulk_count_a, 0);
    chk("s5_error_id", err_id_a, 0);
    chk("s5_underrun", err_un_a, 0);
    exp_a.delete();
    fifo_a.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    load(0, BB_A, 5'd3, 8'h01, 8'h01, -1);
    wait_done(0, 300);
    chk("s5_fresh_bulk_count", bulk_count_a, 1);

    // Four-byte bulk on the second instance.
    r0 = ren_b;
    load(1, BB_B, 5'd1, 8'hAA, 8'h11, -1);
    wait_done(1, 200);
    chk("s6_bulk_count", bulk_count_b, 1);
    chk("s6_renable_pulses", ren_b - r0, 4);
    chk("s6_beats", beats_b, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
